// File: rtl/instr_loader.sv
// Byte-stream loader: packs bytes MSB-first into 32-bit words and writes them to instruction memory.
// Optional running checksum of written words when LOADER_CHECKSUM_EN is defined.
//
// state | meaning
// IDLE  | waiting for start, not accepting bytes
// RECV  | accepting bytes until a full word is assembled
// WRITE | one-cycle memory write of the assembled word
// DONE  | halt word written or memory full; waiting for start
module instr_loader #(
  parameter int         ADDR_W      = 18,
  parameter int         BASE_ADDR   = 0,
  parameter logic [3:0] HALT_NIBBLE = 4'b1111
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  output logic              busy,
  output logic              done,
  output logic              err_full,
  output logic [ADDR_W:0]   word_count,
  output logic [31:0]       checksum
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RECV  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] BASE    = BASE_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   WC_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]        state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [1:0]        bcnt;
  logic [31:0]       word;
  logic [31:0]       word_shift;
  logic              accept, load_start, ptr_last, is_halt;

  assign accept     = (state == RECV) && byte_valid && byte_ready;
  assign load_start = start && ((state == IDLE) || (state == DONE));
  assign word_shift = {word[23:0], byte_data};
  assign ptr_last   = (ptr == {ADDR_W{1'b1}});
  assign is_halt    = (mem_data[31:28] == HALT_NIBBLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = RECV;
      RECV:       if (accept && (bcnt == 2'd3)) state_nxt = WRITE;
      WRITE:      state_nxt = (is_halt || ptr_last) ? DONE : RECV;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= BASE;
      bcnt       <= 2'd0;
      word       <= 32'd0;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= 32'd0;
      err_full   <= 1'b0;
      word_count <= '0;
    end else begin
      state      <= state_nxt;
      byte_ready <= (state_nxt == RECV);
      busy       <= (state_nxt == RECV) || (state_nxt == WRITE);
      done       <= (state_nxt == DONE);
      mem_we     <= 1'b0;
      if (load_start) begin
        ptr        <= BASE;
        bcnt       <= 2'd0;
        word       <= 32'd0;
        err_full   <= 1'b0;
        word_count <= '0;
      end
      if (accept) begin
        word <= word_shift;
        bcnt <= bcnt + 2'd1;
        if (bcnt == 2'd3) begin
          mem_we   <= 1'b1;
          mem_addr <= ptr;
          mem_data <= word_shift;
        end
      end
      if (state == WRITE) begin
        // pointer saturates at the top; the load ends there instead of wrapping
        if (!ptr_last) ptr <= ptr + PTR_ONE;
        word_count <= word_count + WC_ONE;
        if (!is_halt && ptr_last) err_full <= 1'b1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               checksum <= 32'd0;
    else if (load_start)     checksum <= 32'd0;
    else if (state == WRITE) checksum <= checksum + mem_data;
  end
`else
  assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: full-depth instance plus a 4-word instance for overflow.
module tb_instr_loader;
  logic       clk = 1'b0, reset = 1'b1, start = 1'b0, byte_valid = 1'b0;
  logic [7:0] byte_data = 8'd0;

  logic        b_ready, b_we, b_busy, b_done, b_err;
  logic [17:0] b_addr;
  logic [31:0] b_data, b_cs;
  logic [18:0] b_wc;
  logic        s_ready, s_we, s_busy, s_done, s_err;
  logic [1:0]  s_addr;
  logic [31:0] s_data, s_cs;
  logic [2:0]  s_wc;

  instr_loader #(.ADDR_W(18)) dut_big (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(b_ready), .mem_we(b_we), .mem_addr(b_addr), .mem_data(b_data), .busy(b_busy),
    .done(b_done), .err_full(b_err), .word_count(b_wc), .checksum(b_cs));

  instr_loader #(.ADDR_W(2)) dut_small (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(s_ready), .mem_we(s_we), .mem_addr(s_addr), .mem_data(s_data), .busy(s_busy),
    .done(s_done), .err_full(s_err), .word_count(s_wc), .checksum(s_cs));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [17:0] b_wa[64];
  logic [31:0] b_wd[64];
  logic [1:0]  s_wa[64];
  logic [31:0] s_wd[64];
  int b_n = 0, s_n = 0;

  // write log: one entry per cycle the strobe is seen high
  always @(negedge clk) begin
    if (b_we) begin
      if (b_n < 64) begin b_wa[b_n] = b_addr; b_wd[b_n] = b_data; end
      b_n++;
    end
    if (s_we) begin
      if (s_n < 64) begin s_wa[s_n] = s_addr; s_wd[s_n] = s_data; end
      s_n++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    byte_valid = 1'b1; byte_data = b;
    while (!b_ready && guard < 20) begin tick(); guard++; end
    check("byte_ready_wait", 64'(b_ready), 64'd1);
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[31-8*i -: 8]);
      if (i < 3) repeat (gap) tick();
    end
  endtask

  int bbase, sbase;

  initial begin
    // 1: reset in idle, unstarted bytes ignored
    repeat (2) tick();
    reset = 1'b0; tick();
    reset = 1'b1; tick();
    check("rst_done", 64'(b_done), 64'd0);
    check("rst_busy", 64'(b_busy), 64'd0);
    check("rst_ready", 64'(b_ready), 64'd0);
    reset = 1'b0;
    byte_valid = 1'b1; byte_data = 8'h55;
    repeat (4) tick();
    check("idle_ready", 64'(b_ready), 64'd0);
    check("idle_no_we", 64'(b_n), 64'd0);
    check("idle_wc", 64'(b_wc), 64'd0);
    check("idle_addr", 64'(b_addr), 64'd0);
    check("idle_data", 64'(b_data), 64'd0);
    check("idle_cs", 64'(b_cs), 64'd0);
    byte_valid = 1'b0;

    // 2: first word back-to-back
    pulse_start();
    bbase = b_n;
    send_word(32'h12345678, 0);
    tick();
    check("w0_count", 64'(b_n - bbase), 64'd1);
    check("w0_addr", 64'(b_wa[bbase]), 64'd0);
    check("w0_data", 64'(b_wd[bbase]), 64'h12345678);
    check("w0_wc", 64'(b_wc), 64'd1);
    check("w0_recv_ready", 64'(b_ready), 64'd1);
    check("w0_recv_busy", 64'(b_busy), 64'd1);

    // 3: halt word with bubbles
    send_word(32'hF0000000, 3);
    tick();
    check("halt_count", 64'(b_n - bbase), 64'd2);
    check("halt_addr", 64'(b_wa[bbase+1]), 64'd1);
    check("halt_data", 64'(b_wd[bbase+1]), 64'hF0000000);
    check("halt_done", 64'(b_done), 64'd1);
    check("halt_wc", 64'(b_wc), 64'd2);
    check("halt_err", 64'(b_err), 64'd0);
    repeat (3) tick();
    check("halt_ready_held", 64'(b_ready), 64'd0);
    check("halt_done_held", 64'(b_done), 64'd1);
    check("small_halt_done", 64'(s_done), 64'd1);

    // 4: overflow on the 4-word instance
    pulse_start();
    sbase = s_n;
    for (int k = 1; k <= 4; k++) send_word(32'(k), 0);
    tick();
    check("ovf_count", 64'(s_n - sbase), 64'd4);
    check("ovf_addr0", 64'(s_wa[sbase]), 64'd0);
    check("ovf_addr3", 64'(s_wa[sbase+3]), 64'd3);
    check("ovf_data3", 64'(s_wd[sbase+3]), 64'd4);
    check("ovf_done", 64'(s_done), 64'd1);
    check("ovf_err", 64'(s_err), 64'd1);
    check("ovf_wc", 64'(s_wc), 64'd4);
    check("big_still_recv", 64'(b_busy), 64'd1);
    pulse_start();
    check("restart_err", 64'(s_err), 64'd0);
    check("restart_done", 64'(s_done), 64'd0);
    check("restart_busy", 64'(s_busy), 64'd1);
    sbase = s_n; bbase = b_n;
    send_word(32'h00000009, 0);
    tick();
    check("restart_addr", 64'(s_wa[sbase]), 64'd0);
    check("restart_data", 64'(s_wd[sbase]), 64'd9);
    check("busy_start_ignored_wc", 64'(b_wc), 64'd5);
    check("busy_start_ignored_addr", 64'(b_wa[bbase]), 64'd4);

    // 5: reset during a partial word; start together with reset is dropped
    reset = 1'b1; start = 1'b1; tick();
    check("rst_wc", 64'(b_wc), 64'd0);
    check("rst_addr", 64'(b_addr), 64'd0);
    start = 1'b0; reset = 1'b0; tick();
    check("rst_start_busy", 64'(b_busy), 64'd0);
    check("rst_start_ready", 64'(b_ready), 64'd0);
    pulse_start();
    bbase = b_n;
    send_byte(8'hAA);
    send_byte(8'hBB);
    pulse_reset();
    tick();
    check("partial_no_we", 64'(b_n - bbase), 64'd0);
    check("partial_busy", 64'(b_busy), 64'd0);
    pulse_start();
    send_word(32'hAABBCCDD, 0);
    tick();
    check("after_rst_count", 64'(b_n - bbase), 64'd1);
    check("after_rst_addr", 64'(b_wa[bbase]), 64'd0);
    check("after_rst_data", 64'(b_wd[bbase]), 64'hAABBCCDD);

    // 6: checksum
    pulse_reset();
    pulse_start();
    send_word(32'h80000000, 0);
    send_word(32'h80000001, 0);
    send_word(32'hF0000000, 0);
    tick();
    check("cs_done", 64'(b_done), 64'd1);
    check("cs_wc", 64'(b_wc), 64'd3);
`ifdef LOADER_CHECKSUM_EN
    check("cs_value", 64'(b_cs), 64'hF0000001);
`else
    check("cs_value", 64'(b_cs), 64'd0);
`endif
    repeat (2) tick();
`ifdef LOADER_CHECKSUM_EN
    check("cs_held", 64'(b_cs), 64'hF0000001);
`else
    check("cs_held", 64'(b_cs), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
